systolic_ctrl: RTL and testbench

//  Sequencer for the 3x3 systolic array. Holds a 3x3 weight bank and pulses load_weights once per job.

---
 rtl/systolic_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_ctrl
//   Sequencer for a 3x3 systolic array. Holds the 3x3 weight bank, pulses
//   arr_load once per job, skews accepted input vectors onto the array rows,
//   deskews the column results and emits one aligned result vector per
//   accepted input, followed by a one-cycle done pulse.
//
// Ports
//   clk, rst                  clock (posedge) and async active-low reset
//   cfg_we/cfg_addr/cfg_data  weight bank write port, index r*3+c (0..8)
//   job_start/job_len         start pulse and vector count (IDLE only)
//   in_valid/in_ready/in_data input vector stream {x3,x2,x1}
//   arr_start/arr_load        array enable and weight-capture strobe
//   arr_in/arr_w/arr_out      skewed row inputs, weight bank, column outputs
//   out_valid/out_data        aligned result vector {y3,y2,y1}
//   busy/done                 job in progress / job finished pulse
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for job_start
// S_LOAD  | arr_load high for one cycle, PEs capture the weight bank
// S_STREAM| accepting input vectors until job_len have been taken
// S_DRAIN | no new input; waiting for in-flight results to come out
// S_DONE  | one-cycle done pulse
// -----------------------------------------------------------------------------
module systolic_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ARRAY_LAT = 3,
  parameter int LEN_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_addr,
  input  logic [DATA_W-1:0]     cfg_data,
  input  logic                  job_start,
  input  logic [LEN_W-1:0]      job_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3*DATA_W-1:0]   in_data,
  output logic                  arr_start,
  output logic                  arr_load,
  output logic [3*DATA_W-1:0]   arr_in,
  output logic [9*DATA_W-1:0]   arr_w,
  input  logic [3*DATA_W-1:0]   arr_out,
  output logic                  out_valid,
  output logic [3*DATA_W-1:0]   out_data,
  output logic                  busy,
  output logic                  done
);

  // Tag stages cover cycles t+1 .. t+ARRAY_LAT+3; the final stage feeds
  // out_valid, so results surface at t+ARRAY_LAT+4.
  localparam int TAG_D = ARRAY_LAT + 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      acc_q, acc_d;
  logic [LEN_W-1:0]      emit_q, emit_d;
  logic [9*DATA_W-1:0]   w_q, w_d;

  // Row skew: row 1 one stage, row 2 two stages, row 3 three stages.
  logic [DATA_W-1:0]     s1_q, s1_d;
  logic [DATA_W-1:0]     s2a_q, s2a_d, s2b_q, s2b_d;
  logic [DATA_W-1:0]     s3a_q, s3a_d, s3b_q, s3b_d, s3c_q, s3c_d;

  // Column deskew: column 1 delayed two cycles, column 2 one, column 3 none.
  logic [DATA_W-1:0]     d1a_q, d1a_d, d1b_q, d1b_d;
  logic [DATA_W-1:0]     d2a_q, d2a_d;

  logic [TAG_D-1:0]      tag_q, tag_d;
  logic                  out_valid_q, out_valid_d;
  logic [3*DATA_W-1:0]   out_data_q, out_data_d;
  logic                  accept;

  assign in_ready  = (state_q == S_STREAM) && (acc_q < len_q);
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q != S_IDLE);
  assign arr_w     = w_q;
  assign arr_in    = {s3c_q, s2b_q, s1_q};
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // FSM next state and strobes
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    acc_d     = acc_q;
    emit_d    = emit_q + LEN_W'(out_valid_q);
    arr_start = 1'b0;
    arr_load  = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (job_start) begin
          len_d   = job_len;
          acc_d   = '0;
          emit_d  = '0;
          state_d = (job_len != '0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        arr_load  = 1'b1;
        arr_start = 1'b1;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        arr_start = 1'b1;
        if (accept) begin
          acc_d = acc_q + LEN_W'(1);
          if (acc_d == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        arr_start = 1'b1;
        // emit_d includes a result leaving the pipe this cycle
        if ((tag_q == '0) && (emit_d == len_q)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Weight bank: writable in any state; PEs only sample it on arr_load.
  always_comb begin
    w_d = w_q;
    if (cfg_we && (cfg_addr < 4'd9)) w_d[cfg_addr*DATA_W +: DATA_W] = cfg_data;
  end

  // Skew, tag and deskew datapath
  always_comb begin
    s1_d  = accept ? in_data[0*DATA_W +: DATA_W] : '0;
    s2a_d = accept ? in_data[1*DATA_W +: DATA_W] : '0;
    s3a_d = accept ? in_data[2*DATA_W +: DATA_W] : '0;
    s2b_d = s2a_q;
    s3b_d = s3a_q;
    s3c_d = s3b_q;

    tag_d       = {tag_q[TAG_D-2:0], accept};
    out_valid_d = tag_q[TAG_D-1];

    d1a_d = arr_out[0*DATA_W +: DATA_W];
    d1b_d = d1a_q;
    d2a_d = arr_out[1*DATA_W +: DATA_W];

    // Column 3 arrives last; the other columns have been held to line up.
    out_data_d = out_data_q;
    if (tag_q[TAG_D-1]) out_data_d = {arr_out[2*DATA_W +: DATA_W], d2a_q, d1b_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      acc_q       <= '0;
      emit_q      <= '0;
      w_q         <= '0;
      s1_q        <= '0;
      s2a_q       <= '0;
      s2b_q       <= '0;
      s3a_q       <= '0;
      s3b_q       <= '0;
      s3c_q       <= '0;
      d1a_q       <= '0;
      d1b_q       <= '0;
      d2a_q       <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      emit_q      <= emit_d;
      w_q         <= w_d;
      s1_q        <= s1_d;
      s2a_q       <= s2a_d;
      s2b_q       <= s2b_d;
      s3a_q       <= s3a_d;
      s3b_q       <= s3b_d;
      s3c_q       <= s3c_d;
      d1a_q       <= d1a_d;
      d1b_q       <= d1b_d;
      d2a_q       <= d2a_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_ctrl
//   Directed bench for systolic_ctrl. A behavioural 3x3 array model sits on
//   arr_in/arr_w/arr_out: it captures the weight bank on arr_load and produces
//   column c (1..3) of y = x*W in cycle t+4+(c-1) for a vector accepted in t.
// -----------------------------------------------------------------------------
module tb_systolic_ctrl;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cfg_we = 1'b0;
  logic [3:0]      cfg_addr = '0;
  logic [DW-1:0]   cfg_data = '0;
  logic            job_start = 1'b0;
  logic [7:0]      job_len = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3*DW-1:0] in_data = '0;
  logic            arr_start, arr_load;
  logic [3*DW-1:0] arr_in;
  logic [9*DW-1:0] arr_w;
  logic [3*DW-1:0] arr_out;
  logic            out_valid;
  logic [3*DW-1:0] out_data;
  logic            busy, done;

  always #5 clk = ~clk;

  systolic_ctrl #(.DATA_W(DW), .ARRAY_LAT(3), .LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .job_start(job_start), .job_len(job_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .arr_start(arr_start), .arr_load(arr_load), .arr_in(arr_in),
    .arr_w(arr_w), .arr_out(arr_out),
    .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .done(done)
  );

  // Array model: hist[j] holds arr_in from j+1 cycles ago.
  logic [3*DW-1:0] hist [0:4];
  logic [9*DW-1:0] wl;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < 5; j++) hist[j] <= '0;
      wl <= '0;
    end else begin
      hist[0] <= arr_in;
      for (int j = 1; j < 5; j++) hist[j] <= hist[j-1];
      if (arr_load) wl <= arr_w;
    end
  end

  always_comb begin
    arr_out = '0;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 3; r++) begin
        arr_out[c*DW +: DW] = arr_out[c*DW +: DW]
                            + wl[(r*3+c)*DW +: DW] * hist[2+c-r][r*DW +: DW];
      end
    end
  end

  // Cycle counter and output monitor
  int              cyc = 0;
  int              ov_cyc[$];
  logic [3*DW-1:0] ov_dat[$];
  int              done_cnt = 0, load_cnt = 0, rdy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (out_valid) begin
        ov_cyc.push_back(cyc);
        ov_dat.push_back(out_data);
      end
      if (done)     done_cnt++;
      if (arr_load) load_cnt++;
      if (in_ready) rdy_cnt++;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3*DW-1:0] vec(input int a3, input int a2, input int a1);
    return {16'(a3), 16'(a2), 16'(a1)};
  endfunction

  task automatic load_w(input logic [DW-1:0] w [9]);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 4'(i); cfg_data = w[i];
    end
    // out-of-range index must leave the bank alone
    @(negedge clk);
    cfg_addr = 4'd12; cfg_data = 16'hdead;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic clr_mon();
    ov_cyc.delete();
    ov_dat.delete();
    done_cnt = 0; load_cnt = 0; rdy_cnt = 0;
  endtask

  task automatic run_job(input string nm, input int len,
                         input logic [3*DW-1:0] vin [4], input logic [3*DW-1:0] yexp [4],
                         input bit toggle, input bit poke);
    int acc_cyc[$];
    int i = 0;
    bit ph = 1'b0;
    int start_cyc;
    int dcyc = -1;
    clr_mon();
    @(negedge clk);
    job_start = 1'b1; job_len = 8'(len); start_cyc = cyc;
    @(negedge clk);
    job_start = 1'b0; job_len = 8'($urandom);
    for (int n = 0; n < 100; n++) begin
      if (done) begin
        dcyc = cyc;
        break;
      end
      job_start = poke && (n == 3);
      in_valid  = 1'($urandom);
      in_data   = 48'($urandom);
      if (in_ready) begin
        in_valid = 1'b0;
        if (i < len && (!toggle || !ph)) begin
          in_valid = 1'b1;
          in_data  = vin[i];
          acc_cyc.push_back(cyc);
          i++;
        end
        ph = ~ph;
      end
      @(negedge clk);
    end
    job_start = 1'b0;
    in_valid  = 1'b0;
    chk({nm, "_done_seen"}, 64'(dcyc >= 0), 64'd1);
    chk({nm, "_nout"}, 64'(ov_cyc.size()), 64'(len));
    for (int k = 0; k < len && k < ov_cyc.size() && k < acc_cyc.size(); k++) begin
      chk({nm, "_out_cyc"}, 64'(ov_cyc[k]), 64'(acc_cyc[k] + 7));
      chk({nm, "_out_dat"}, 64'(ov_dat[k]), 64'(yexp[k]));
    end
    if (len == 0) begin
      chk({nm, "_done_lat"}, 64'(dcyc), 64'(start_cyc + 1));
      chk({nm, "_no_ready"}, 64'(rdy_cnt), 64'd0);
    end else if (ov_cyc.size() > 0) begin
      chk({nm, "_done_after"}, 64'(dcyc), 64'(ov_cyc[ov_cyc.size()-1] + 1));
    end
    chk({nm, "_loads"}, 64'(load_cnt), 64'(len != 0));
    @(negedge clk);
    chk({nm, "_idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  logic [DW-1:0]   w_id [9];
  logic [DW-1:0]   w_seq [9];
  logic [3*DW-1:0] vin [4];
  logic [3*DW-1:0] yexp [4];

  initial begin
    for (int i = 0; i < 9; i++) begin
      w_id[i]  = (i % 4 == 0) ? 16'd1 : 16'd0;
      w_seq[i] = 16'(i + 1);
    end

    // 1: reset with random inputs
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      cfg_we = 1'($urandom); cfg_addr = 4'($urandom); cfg_data = 16'($urandom);
      job_start = 1'($urandom); job_len = 8'($urandom);
      in_valid = 1'($urandom); in_data = 48'($urandom);
    end
    #1;
    chk("rst_ctl", {58'd0, in_ready, arr_start, arr_load, out_valid, busy, done}, 64'd0);
    chk("rst_arr_in", 64'(arr_in), 64'd0);
    chk("rst_wbank", 64'(|arr_w), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    cfg_we = 1'b0; job_start = 1'b0; job_len = '0; in_valid = 1'b0; in_data = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {62'd0, busy, in_ready}, 64'd0);

    // 2: identity, single vector
    load_w(w_id);
    vin  = '{vec(3,2,1), 48'd0, 48'd0, 48'd0};
    yexp = '{vec(3,2,1), 48'd0, 48'd0, 48'd0};
    run_job("ident1", 1, vin, yexp, 1'b0, 1'b0);

    // 3: sequential weights, back-to-back
    load_w(w_seq);
    vin  = '{vec(0,0,1), vec(0,1,0), vec(1,0,0), vec(1,1,1)};
    yexp = '{vec(3,2,1), vec(6,5,4), vec(9,8,7), vec(18,15,12)};
    run_job("b2b", 4, vin, yexp, 1'b0, 1'b0);

    // 4: same job with bubbles
    run_job("bubble", 4, vin, yexp, 1'b1, 1'b0);

    // 5: empty job, then job_start while busy
    run_job("len0", 0, vin, yexp, 1'b0, 1'b0);
    run_job("poke", 2, vin, yexp, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("poke_stays_idle", 64'(busy), 64'd0);

    // 6: reset while draining two vectors
    clr_mon();
    @(negedge clk);
    job_start = 1'b1; job_len = 8'd2;
    @(negedge clk);                       // LOAD
    job_start = 1'b0; in_valid = 1'b1; in_data = vec(0,0,1);
    @(negedge clk);                       // STREAM, first accept
    @(negedge clk);                       // STREAM, second accept
    in_data = vec(1,1,1);
    @(negedge clk);                       // DRAIN
    in_valid = 1'b0;
    chk("pre_rst_drain", {62'd0, busy, in_ready}, 64'd2);
    rst = 1'b0;
    #1;
    chk("midrst_ctl", {58'd0, in_ready, arr_start, arr_load, out_valid, busy, done}, 64'd0);
    chk("midrst_arr_in", 64'(arr_in), 64'd0);
    chk("midrst_wbank", 64'(|arr_w), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_out", 64'(ov_cyc.size()), 64'd0);
    chk("midrst_no_done", 64'(done_cnt), 64'd0);

    load_w(w_id);
    vin  = '{vec(3,2,1), vec(9,8,7), 48'd0, 48'd0};
    yexp = '{vec(3,2,1), vec(9,8,7), 48'd0, 48'd0};
    run_job("after_rst", 2, vin, yexp, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
